// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment pair capture block.
// Segment patterns are active-high with bit0 = a through bit6 = g.
package seg_pkg;

    localparam int SEG_PERIOD_DEFAULT = 251;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } seg_state_e;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational seven-segment to hex nibble decoder.
// Unknown patterns decode to 0 with the illegal flag raised.
module seg_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] segment,
    output logic [3:0] nib,
    output logic       illegal
);

    always_comb begin
        nib     = 4'h0;
        illegal = 1'b0;
        case (segment)
            SEG_0:   nib = 4'h0;
            SEG_1:   nib = 4'h1;
            SEG_2:   nib = 4'h2;
            SEG_3:   nib = 4'h3;
            SEG_4:   nib = 4'h4;
            SEG_5:   nib = 4'h5;
            SEG_6:   nib = 4'h6;
            SEG_7:   nib = 4'h7;
            SEG_8:   nib = 4'h8;
            SEG_9:   nib = 4'h9;
            SEG_A:   nib = 4'hA;
            SEG_B:   nib = 4'hB;
            SEG_C:   nib = 4'hC;
            SEG_D:   nib = 4'hD;
            SEG_E:   nib = 4'hE;
            SEG_F:   nib = 4'hF;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// Reassembles a high/low digit pair from a strobed seven-segment bus and
// polices the strobe spacing with a saturating gap counter.
module seg_capture
    import seg_pkg::*;
#(
    parameter int PERIOD = SEG_PERIOD_DEFAULT,
    parameter int CBITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segment,
    input  logic        sig,
    output logic [13:0] word,
    output logic [3:0]  hi_nib,
    output logic [3:0]  lo_nib,
    output logic        valid,
    output logic        bad_code,
    output logic        err,
    output logic        locked
);

    localparam logic [CBITS-1:0] GAP_MAX  = '1;
    localparam logic [31:0]      GAP_GOOD = 32'(PERIOD - 1);

    seg_state_e       state;
    seg_state_e       state_nxt;
    logic [CBITS-1:0] gap_cnt;
    logic             first;
    logic [6:0]       hi_reg;
    logic             gap_ok;
    logic             take_hi;
    logic             take_lo;
    logic             gap_err;
    logic [3:0]       dec_hi_nib;
    logic [3:0]       dec_lo_nib;
    logic             dec_hi_bad;
    logic             dec_lo_bad;

    // The first strobe after reset or an error has no reference point.
    assign gap_ok = first || ({{(32-CBITS){1'b0}}, gap_cnt} == GAP_GOOD);

    seg_to_hex u_dec_hi (
        .segment (hi_reg),
        .nib     (dec_hi_nib),
        .illegal (dec_hi_bad)
    );

    seg_to_hex u_dec_lo (
        .segment (segment),
        .nib     (dec_lo_nib),
        .illegal (dec_lo_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_HI;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take_hi   = 1'b0;
        take_lo   = 1'b0;
        gap_err   = 1'b0;
        if (sig) begin
            if (!gap_ok) begin
                gap_err   = 1'b1;
                state_nxt = WAIT_HI;
            end else begin
                case (state)
                    WAIT_HI: begin
                        take_hi   = 1'b1;
                        state_nxt = WAIT_LO;
                    end
                    WAIT_LO: begin
                        take_lo   = 1'b1;
                        state_nxt = WAIT_HI;
                    end
                    default: state_nxt = WAIT_HI;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
            first   <= 1'b1;
            hi_reg  <= 7'h00;
        end else begin
            if (sig)                    gap_cnt <= '0;
            else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;

            if (gap_err)  first <= 1'b1;
            else if (sig) first <= 1'b0;

            if (take_hi) hi_reg <= segment;
        end
    end

    // valid and err are single-cycle pulses, never together; word, nibbles
    // and bad_code change only in the cycle valid is high and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word     <= 14'h0000;
            hi_nib   <= 4'h0;
            lo_nib   <= 4'h0;
            bad_code <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
            locked   <= 1'b0;
        end else begin
            valid <= take_lo;
            err   <= gap_err;
            if (take_lo) begin
                word     <= {hi_reg, segment};
                hi_nib   <= dec_hi_nib;
                lo_nib   <= dec_lo_nib;
                bad_code <= dec_hi_bad | dec_lo_bad;
                locked   <= 1'b1;
            end else if (gap_err) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios plus random strobe traffic,
// checked against a timestamp-based model of the pairing and spacing rules.
module tb_seg_capture;

    localparam int PERIOD = 251;
    localparam int CBITS  = 8;
    localparam int W      = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sig = 1'b0;
    logic [6:0]  segment = 7'h00;
    logic [13:0] word;
    logic [3:0]  hi_nib;
    logic [3:0]  lo_nib;
    logic        valid;
    logic        bad_code;
    logic        err;
    logic        locked;

    seg_capture #(.PERIOD(PERIOD), .CBITS(CBITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .segment  (segment),
        .sig      (sig),
        .word     (word),
        .hi_nib   (hi_nib),
        .lo_nib   (lo_nib),
        .valid    (valid),
        .bad_code (bad_code),
        .err      (err),
        .locked   (locked)
    );

    // clock / cycle stamp
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard and model state
    logic [W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int exp_valid_n = 0;
    int exp_err_n = 0;
    int seen_valid = 0;
    int seen_err = 0;
    int last_t = 0;
    bit m_first;
    bit m_have_hi;
    logic [6:0]  m_hi;
    logic [13:0] m_word;
    logic [3:0]  m_hi_nib;
    logic [3:0]  m_lo_nib;
    logic        m_bad;
    logic        m_locked;

    logic [6:0] legal_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void decode(input logic [6:0] s, output logic [3:0] n, output bit bad);
        n = 4'h0;
        bad = 1'b1;
        for (int i = 0; i < 16; i++)
            if (legal_tab[i] == s) begin
                n = 4'(i);
                bad = 1'b0;
            end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic model_reset();
        m_first   = 1'b1;
        m_have_hi = 1'b0;
        m_hi      = 7'h00;
        m_word    = 14'h0000;
        m_hi_nib  = 4'h0;
        m_lo_nib  = 4'h0;
        m_bad     = 1'b0;
        m_locked  = 1'b0;
    endtask

    task automatic check_held(input string tag);
        chk({tag, "_word"},   32'(word),     32'(m_word));
        chk({tag, "_hi_nib"}, 32'(hi_nib),   32'(m_hi_nib));
        chk({tag, "_lo_nib"}, 32'(lo_nib),   32'(m_lo_nib));
        chk({tag, "_bad"},    32'(bad_code), 32'(m_bad));
        chk({tag, "_locked"}, 32'(locked),   32'(m_locked));
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sig = 1'b0;
            segment = 7'($urandom);
            @(posedge clk);
            #1;
            seen_valid += int'(valid);
            seen_err   += int'(err);
        end
    endtask

    task automatic strobe(input logic [6:0] s);
        int gap;
        int sat;
        bit good;
        bit ev;
        bit ee;
        logic [3:0] nh;
        logic [3:0] nl;
        bit bh;
        bit bl;
        @(negedge clk);
        sig = 1'b1;
        segment = s;
        @(posedge clk);
        #1;
        gap = cyc - last_t;
        last_t = cyc;
        sat = (gap - 1 > (2**CBITS) - 1) ? (2**CBITS) - 1 : gap - 1;
        good = m_first || (sat == PERIOD - 1);
        ev = 1'b0;
        ee = 1'b0;
        if (!good) begin
            ee = 1'b1;
            m_locked = 1'b0;
            m_first = 1'b1;
            m_have_hi = 1'b0;
            exp_err_n++;
        end else if (!m_have_hi) begin
            m_hi = s;
            m_have_hi = 1'b1;
            m_first = 1'b0;
        end else begin
            m_word = {m_hi, s};
            decode(m_hi, nh, bh);
            decode(s, nl, bl);
            m_hi_nib = nh;
            m_lo_nib = nl;
            m_bad = bh | bl;
            m_locked = 1'b1;
            m_have_hi = 1'b0;
            ev = 1'b1;
            exp_q.push_back(m_word);
            exp_valid_n++;
        end
        seen_valid += int'(valid);
        seen_err   += int'(err);
        if (valid && exp_q.size() > 0) chk("sb_word", 32'(word), 32'(exp_q.pop_front()));
        chk("valid", 32'(valid), 32'(ev));
        chk("err",   32'(err),   32'(ee));
        check_held("strobe");
    endtask

    task automatic strobe_gap(input int g, input logic [6:0] s);
        idle(g - 1);
        strobe(s);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err",   32'(err),   32'd0);
        check_held("rst");
        @(negedge clk);
        rst = 1'b0;
        sig = 1'b0;
    endtask

    initial begin
        logic [6:0] s;
        int kind;
        int g;
        model_reset();
        #2 rst = 1'b1;
        #1;
        chk("init_valid", 32'(valid), 32'd0);
        chk("init_err",   32'(err),   32'd0);
        check_held("init");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // basic pair at nominal spacing
        strobe_gap(10, 7'h5B);
        strobe_gap(PERIOD, 7'h66);
        chk("pair1_word", 32'(word), 32'h2DE6);
        chk("pair1_hi", 32'(hi_nib), 32'd2);
        chk("pair1_lo", 32'(lo_nib), 32'd4);
        chk("pair1_bad", 32'(bad_code), 32'd0);
        chk("pair1_locked", 32'(locked), 32'd1);

        // illegal low digit
        strobe_gap(PERIOD, 7'h7F);
        strobe_gap(PERIOD, 7'h00);
        chk("pair2_valid", 32'(valid), 32'd1);
        chk("pair2_hi", 32'(hi_nib), 32'd8);
        chk("pair2_lo", 32'(lo_nib), 32'd0);
        chk("pair2_bad", 32'(bad_code), 32'd1);

        // short gap, then recovery
        strobe_gap(200, 7'h12);
        chk("short_err", 32'(err), 32'd1);
        chk("short_locked", 32'(locked), 32'd0);
        strobe_gap(PERIOD, 7'h3F);
        strobe_gap(PERIOD, 7'h06);
        chk("recov_word", 32'(word), 32'h1F86);
        chk("recov_locked", 32'(locked), 32'd1);

        // saturation: long silence, and a gap that would alias if the counter wrapped
        strobe_gap(401, 7'h6D);
        chk("sat400_err", 32'(err), 32'd1);
        strobe_gap(5, 7'h3F);
        strobe_gap(PERIOD + 256, 7'h06);
        chk("sat507_err", 32'(err), 32'd1);
        strobe_gap(3, 7'h06);
        strobe_gap(PERIOD, 7'h4F);
        chk("sat_recov_word", 32'(word), 32'h034F);

        // sig held high: back-to-back strobes
        strobe_gap(PERIOD, 7'h3F);
        strobe_gap(1, 7'h06);
        chk("held_err", 32'(err), 32'd1);

        // reset between high and low digit
        strobe_gap(9, 7'h66);
        strobe_gap(PERIOD, 7'h6D);
        strobe_gap(PERIOD, 7'h7D);
        idle(20);
        apply_reset();
        strobe_gap(30, 7'h07);
        strobe_gap(PERIOD, 7'h7F);
        chk("rst_pair_word", 32'(word), 32'h03FF);
        chk("rst_pair_locked", 32'(locked), 32'd1);

        // random traffic
        for (int i = 0; i < 30; i++) begin
            s = ($urandom_range(0, 1) == 1) ? legal_tab[$urandom_range(0, 15)] : 7'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0)      g = PERIOD - $urandom_range(1, 50);
            else if (kind == 1) g = PERIOD + $urandom_range(1, 20);
            else if (kind == 2) g = 1;
            else                g = PERIOD;
            strobe_gap(g, s);
        end
        idle(5);

        chk("valid_count", 32'(seen_valid), 32'(exp_valid_n));
        chk("err_count",   32'(seen_err),   32'(exp_err_n));
        chk("sb_drained",  32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter PERIOD, default 251: expected clk cycles between consecutive sig strobes.
REQ-002 SHALL have parameter CBITS, default 8: gap counter width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port segment, input, 7: multiplexed segment bus; bit0=a … bit6=g, active-high.
REQ-006 SHALL have port sig, input, 1: digit strobe; segment is valid in the same cycle sig=1.
REQ-007 SHALL have port word, output, 14: reassembled pair, [13:7] = high digit, [6:0] = low digit.
REQ-008 SHALL have port hi_nib, output, 4: decoded high digit.
REQ-009 SHALL have port lo_nib, output, 4: decoded low digit.
REQ-010 SHALL have port valid, output, 1: one-cycle pulse when word, hi_nib, lo_nib and bad_code update.
REQ-011 SHALL have port bad_code, output, 1: either digit of the last word is not a legal hex pattern.
REQ-012 SHALL have port err, output, 1: one-cycle pulse on a strobe-spacing violation.
REQ-013 SHALL have port locked, output, 1: a complete correctly spaced pair has been received since the last reset or error.

Function
REQ-014 SHALL implement FSM states WAIT_HI and WAIT_LO.
REQ-015 SHALL enter WAIT_HI after reset and treat the first strobe in WAIT_HI as the high digit.
REQ-016 SHALL, on sig in WAIT_HI with a good gap, latch segment into hi_reg and go to WAIT_LO.
REQ-017 SHALL, on sig in WAIT_LO with a good gap, on the next edge: word={hi_reg, segment}; decode both digits; pulse valid; set locked=1; return to WAIT_HI.
REQ-018 SHALL use a gap counter that clears to 0 on every strobe, increments by 1 otherwise, and saturates at 2^CBITS-1 (no wrap).
REQ-019 SHALL define a gap as good when the counter equals PERIOD-1 at the strobe.
REQ-020 SHALL exempt the first strobe after reset or after an error from the gap check.
REQ-021 SHALL, on a bad gap in either state: pulse err for one cycle; clear locked; discard the strobe; go to WAIT_HI; treat the next strobe as the new first (unchecked) high digit.
REQ-022 SHALL use the legal decode table 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71 (hex).
REQ-023 SHALL decode any pattern outside the table to nibble 0 and set bad_code=1 for that word.
REQ-024 SHALL hold word, nibbles and bad_code between valid pulses.
REQ-025 SHALL keep valid and err mutually exclusive.
REQ-026 SHALL give latency of one clk from the low-digit strobe edge to the valid pulse.
REQ-027 SHALL treat a sig held high for consecutive cycles as separate strobes; the gap of 1 is bad unless PERIOD=1.

Reset
REQ-028 SHALL set, on rst=1 asynchronously: word=0, hi_nib=0, lo_nib=0, valid=0, bad_code=0, err=0, locked=0, FSM=WAIT_HI, gap counter=0, hi_reg=0.
REQ-029 SHALL, on rst asserted mid-pair, discard the partial pair with no valid and no err pulse.

Structure
REQ-030 SHALL place the FSM state typedef, the segment-pattern constants and the PERIOD default in package seg_pkg.
REQ-031 SHALL instantiate the combinational sub-module seg_to_hex (7-bit in, 4-bit nibble plus illegal flag) twice.

Verification
REQ-032 SHALL cover: reset, then strobes at gap 251 with segment 5B then 66 -> one valid, word=0x2DE6, hi_nib=2, lo_nib=4, bad_code=0, locked=1.
REQ-033 SHALL cover: locked, then pair 7F, 00 -> valid, hi_nib=8, lo_nib=0, bad_code=1.
REQ-034 SHALL cover: locked, then one strobe at gap 200 -> err pulse, locked=0, no valid; the next two strobes at gap 251 (3F, 06) -> valid, word=0x1F86, locked=1.
REQ-035 SHALL cover: no sig for 400 cycles, then a strobe -> counter saturated at 255, err pulse, no wrap.
REQ-036 SHALL cover: rst asserted between the high and low strobe -> outputs at reset values immediately; the following strobe is captured as the high digit.
